acp_burst_reader: RTL and testbench

//  Read-side DMA engine inside the accelerator, directly behind its 64-bit AXI master (ACP) port.

---
 rtl/acp_pkg.sv | 17 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/acp_burst_reader.sv | 184 ++++++++++++++++++
 tb/tb_acp_burst_reader.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acp_pkg.sv
// Shared AXI constants and the burst reader's state encoding.
package acp_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;
  localparam logic [3:0] ARCACHE_ACP    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/acp_burst_reader.sv
// Read DMA behind the 64-bit ACP master: splits a command into 4 KB-safe INCR
// bursts, issues them only when the data FIFO can absorb them, streams data out.
module acp_burst_reader
  import acp_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          LEN_W       = 16,
  parameter int          MAX_BURST   = 16,
  parameter int          FIFO_DEPTH  = 32,
  parameter logic [3:0]  ARCACHE_VAL = ARCACHE_ACP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BL_W  = 9;
  localparam int CMP_W = LEN_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              err_q, err_d;
  logic [7:0]        rbeat_q, rbeat_d;
  logic              rready_q, rready_d;

  logic [9:0]        room;
  logic [CMP_W-1:0]  len_full;
  logic [CMP_W-1:0]  credit;
  logic [BL_W-1:0]   burst_len;
  logic              arvalid;
  logic              ar_fire;
  logic              r_live;
  logic              last_expected;
  logic [CNT_W-1:0]  fifo_count;
  logic              len_valid;
  logic [7:0]        len_head;
  logic [CNT_W-1:0]  len_count;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[2:0];

  // Credit only grows while a burst waits for ARREADY, so a raised ARVALID
  // can never fall back before the handshake.
  always_comb begin
    room     = 10'd512 - {1'b0, addr_q[11:3]};
    len_full = CMP_W'(MAX_BURST);
    if (CMP_W'(remaining_q) < len_full) len_full = CMP_W'(remaining_q);
    if (CMP_W'(room) < len_full)        len_full = CMP_W'(room);
    burst_len = BL_W'(len_full);
    credit    = CMP_W'(FIFO_DEPTH) - CMP_W'(fifo_count) - CMP_W'(outstanding_q);
    arvalid   = (state_q == ADDR) && (credit >= CMP_W'(burst_len));
    ar_fire   = arvalid && M_AXI_ARREADY;
    r_live    = M_AXI_RVALID && rready_q && (outstanding_q != '0);
    last_expected = len_valid && (rbeat_q == len_head);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    err_d         = err_q;
    rbeat_d       = rbeat_q;
    rready_d      = 1'b1;
    outstanding_d = outstanding_q
                  + (ar_fire ? CNT_W'(burst_len) : CNT_W'(0))
                  - (r_live  ? CNT_W'(1)         : CNT_W'(0));
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = {cmd_addr[ADDR_W-1:3], 3'b000};
          remaining_d = cmd_beats;
          err_d       = 1'b0;
          state_d     = (cmd_beats == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (ar_fire) begin
          addr_d      = addr_q + (ADDR_W'(burst_len) << 3);
          remaining_d = remaining_q - LEN_W'(burst_len);
          if (remaining_d == '0) state_d = WAIT;
        end
      end
      WAIT: begin
        if ((outstanding_q == '0) && (len_count == '0) && (fifo_count == '0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A bad response or misplaced RLAST is flagged, but the beat still flows.
    if (r_live) begin
      if ((M_AXI_RRESP != AXI_RESP_OKAY) || (M_AXI_RLAST != last_expected)) err_d = 1'b1;
      rbeat_d = last_expected ? 8'd0 : rbeat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      rbeat_q       <= '0;
      rready_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      rbeat_q       <= rbeat_d;
      rready_q      <= rready_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_live),
    .push_data (M_AXI_RDATA),
    .pop       (out_ready),
    .rd_valid  (out_valid),
    .rd_data   (out_data),
    .count     (fifo_count)
  );

  // Lengths of issued bursts, oldest first, to know where RLAST belongs.
  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ar_fire),
    .push_data (8'(burst_len - 9'd1)),
    .pop       (r_live && last_expected),
    .rd_valid  (len_valid),
    .rd_data   (len_head),
    .count     (len_count)
  );

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 8'(burst_len - 9'd1);
  assign M_AXI_ARSIZE  = AXI_SIZE_8B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign M_AXI_ARCACHE = ARCACHE_VAL;
  assign M_AXI_ARPROT  = AXI_PROT_NONE;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_acp_burst_reader.sv
// Bench for acp_burst_reader: random-latency AXI slave plus a queue-based
// reference of the burst split and the expected output stream.
module tb_acp_burst_reader;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_beats;
  logic              busy, done, err;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic [3:0]        M_AXI_ARCACHE;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DATA_W-1:0] M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready;

  always #5 clk = ~clk;

  acp_burst_reader dut (
    .clk (clk), .rst (rst),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_addr (cmd_addr), .cmd_beats (cmd_beats),
    .busy (busy), .done (done), .err (err),
    .M_AXI_ARADDR (M_AXI_ARADDR), .M_AXI_ARLEN (M_AXI_ARLEN), .M_AXI_ARSIZE (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST), .M_AXI_ARCACHE (M_AXI_ARCACHE), .M_AXI_ARPROT (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID), .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA (M_AXI_RDATA), .M_AXI_RRESP (M_AXI_RRESP), .M_AXI_RLAST (M_AXI_RLAST),
    .M_AXI_RVALID (M_AXI_RVALID), .M_AXI_RREADY (M_AXI_RREADY),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  logic [63:0] exp_out[$];
  logic [31:0] slv_addr_q[$];
  int          slv_len_q[$];
  logic [31:0] slv_addr = '0;
  int          slv_left = 0;
  bit          slv_active = 1'b0;
  int          cmd_beat_idx = 0;
  int          err_at = -1;
  int          accepted_beats = 0;
  int          popped_beats = 0;
  int          done_cnt = 0;
  int          out_mode = 0;
  int          cycle = 0;
  int          accept_cycle = 0;
  int          done_cycle = 0;
  bit          accepted = 1'b0;
  bit          prev_ar_wait = 1'b0;
  logic [39:0] prev_ar = '0;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hC0DE_F00D, a};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive the slave and sink at the falling edge, judge the
  // handshakes that the next rising edge will complete, then step past it.
  task automatic apply_stimulus();
    int len;
    @(negedge clk);
    cycle++;
    if (!slv_active && slv_len_q.size() > 0) begin
      slv_addr   = slv_addr_q.pop_front();
      slv_left   = slv_len_q.pop_front();
      slv_active = 1'b1;
    end
    if (slv_active && !rst && ($urandom_range(3) != 0)) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = mem_word(slv_addr);
      M_AXI_RLAST  = (slv_left == 1);
      M_AXI_RRESP  = (cmd_beat_idx == err_at) ? 2'b10 : 2'b00;
    end else begin
      M_AXI_RVALID = 1'b0;
      M_AXI_RDATA  = '0;
      M_AXI_RLAST  = 1'b0;
      M_AXI_RRESP  = 2'b00;
    end
    M_AXI_ARREADY = !rst && ($urandom_range(2) != 0);
    case (out_mode)
      0:       out_ready = !rst;
      1:       out_ready = 1'b0;
      default: out_ready = !rst && ($urandom_range(1) == 1);
    endcase

    if (prev_ar_wait) begin
      check_output("ar_hold_valid", M_AXI_ARVALID, 1);
      check_output("ar_hold_addr_len", {M_AXI_ARADDR, M_AXI_ARLEN}, prev_ar);
    end
    prev_ar_wait = M_AXI_ARVALID && !M_AXI_ARREADY && !rst;
    prev_ar      = {M_AXI_ARADDR, M_AXI_ARLEN};

    if (M_AXI_ARVALID && M_AXI_ARREADY) begin
      len = int'(M_AXI_ARLEN) + 1;
      if (exp_ar_addr.size() == 0) begin
        check_output("ar_unexpected", 1, 0);
      end else begin
        check_output("ar_addr", M_AXI_ARADDR, exp_ar_addr.pop_front());
        check_output("ar_len", M_AXI_ARLEN, exp_ar_len.pop_front() - 1);
      end
      check_output("ar_fixed", {M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARCACHE, M_AXI_ARPROT},
                   {3'b011, 2'b01, 4'b1111, 3'b000});
      slv_addr_q.push_back(M_AXI_ARADDR);
      slv_len_q.push_back(len);
      accepted_beats += len;
      check_output("credit_limit", (accepted_beats - popped_beats) <= 32, 1);
    end

    if (M_AXI_RVALID && M_AXI_RREADY) begin
      slv_addr = slv_addr + 32'd8;
      slv_left--;
      cmd_beat_idx++;
      if (slv_left == 0) slv_active = 1'b0;
    end

    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) check_output("out_extra", 1, 0);
      else                     check_output("out_data", out_data, exp_out.pop_front());
      popped_beats++;
    end

    if (done && !rst) begin
      done_cnt++;
      done_cycle = cycle;
    end
    if (cmd_valid && cmd_ready && !rst) begin
      accepted     = 1'b1;
      accept_cycle = cycle;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic prepare_cmd(input logic [31:0] a, input int beats, input int e_at, input int mode);
    logic [31:0] p;
    int rem, room, len;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_out.delete();
    p = {a[31:3], 3'b000};
    for (int i = 0; i < beats; i++) exp_out.push_back(mem_word(p + 32'(i * 8)));
    rem = beats;
    while (rem > 0) begin
      room = (4096 - int'(p[11:0])) / 8;
      len  = (rem < 16) ? rem : 16;
      if (len > room) len = room;
      exp_ar_addr.push_back(p);
      exp_ar_len.push_back(len);
      p   = p + 32'(len * 8);
      rem = rem - len;
    end
    err_at         = e_at;
    cmd_beat_idx   = 0;
    done_cnt       = 0;
    accepted       = 1'b0;
    accepted_beats = 0;
    popped_beats   = 0;
    out_mode       = mode;
  endtask

  task automatic issue_cmd(input string name, input logic [31:0] a, input int beats);
    int guard = 0;
    cmd_addr  = a;
    cmd_beats = LEN_W'(beats);
    cmd_valid = 1'b1;
    while (!accepted && guard < 20) begin
      apply_stimulus();
      guard++;
    end
    cmd_valid = 1'b0;
    check_output({name, "_accept"}, accepted, 1);
    check_output({name, "_busy"}, busy, 1);
    check_output({name, "_err_clear"}, err, 0);
    check_output({name, "_ar_latency"}, M_AXI_ARVALID, beats > 0);
  endtask

  task automatic finish_cmd(input string name, input int beats, input bit exp_err);
    int guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      apply_stimulus();
      guard++;
      if (out_mode == 1 && guard == 300) begin
        check_output({name, "_held_accepted"}, accepted_beats, 32);
        check_output({name, "_held_popped"}, popped_beats, 0);
        check_output({name, "_held_arvalid"}, M_AXI_ARVALID, 0);
        check_output({name, "_held_out_valid"}, out_valid, 1);
        out_mode = 2;
      end
    end
    check_output({name, "_done_seen"}, done_cnt, 1);
    repeat (3) apply_stimulus();
    check_output({name, "_done_once"}, done_cnt, 1);
    check_output({name, "_err"}, err, exp_err);
    check_output({name, "_busy_low"}, busy, 0);
    check_output({name, "_cmd_ready"}, cmd_ready, 1);
    check_output({name, "_out_left"}, exp_out.size(), 0);
    check_output({name, "_ar_left"}, exp_ar_addr.size(), 0);
    check_output({name, "_beats_out"}, popped_beats, beats);
  endtask

  task automatic run_cmd(input string name, input logic [31:0] a, input int beats,
                         input int e_at, input int mode, input bit exp_err);
    prepare_cmd(a, beats, e_at, mode);
    issue_cmd(name, a, beats);
    finish_cmd(name, beats, exp_err);
  endtask

  initial begin
    int guard;
    logic [31:0] ra;
    int rb;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID = 1'b0;
    M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00;
    M_AXI_RLAST = 1'b0;
    out_ready = 1'b0;

    repeat (3) apply_stimulus();
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_arvalid", M_AXI_ARVALID, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_rready", M_AXI_RREADY, 0);
    rst = 1'b0;
    repeat (2) apply_stimulus();
    check_output("rready_after_rst", M_AXI_RREADY, 1);

    run_cmd("t1_split", 32'h1000_0000, 40, -1, 0, 1'b0);
    run_cmd("t2_4k", 32'h1000_0FE0, 8, -1, 0, 1'b0);
    run_cmd("t3_backpressure", 32'h2000_0000, 64, -1, 1, 1'b0);
    run_cmd("t4_rresp", 32'h2000_1000, 16, 4, 2, 1'b1);

    run_cmd("t5_zero", 32'h2000_2000, 0, -1, 0, 1'b0);
    check_output("t5_done_latency", ((done_cycle - accept_cycle) >= 1) && ((done_cycle - accept_cycle) <= 2), 1);
    check_output("t5_no_ar", accepted_beats, 0);

    prepare_cmd(32'h3000_0000, 64, -1, 0);
    issue_cmd("t6_pre", 32'h3000_0000, 64);
    guard = 0;
    while (cmd_beat_idx < 18 && guard < 500) begin
      apply_stimulus();
      guard++;
    end
    check_output("t6_reached_second_burst", cmd_beat_idx >= 18, 1);
    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_out.delete();
    accepted_beats = 0;
    popped_beats = 0;
    check_output("t6_arvalid", M_AXI_ARVALID, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_out_valid", out_valid, 0);
    check_output("t6_err", err, 0);
    guard = 0;
    while ((slv_active || slv_len_q.size() > 0) && guard < 500) begin
      apply_stimulus();
      guard++;
    end
    check_output("t6_strays_drained", slv_active || (slv_len_q.size() > 0), 0);
    check_output("t6_strays_dropped", out_valid, 0);
    run_cmd("t6_after", 32'h3000_0100, 4, -1, 0, 1'b0);

    for (int n = 0; n < 5; n++) begin
      ra = 32'h4000_0000 | 32'($urandom_range(0, 8191));
      rb = $urandom_range(1, 50);
      run_cmd($sformatf("rand%0d", n), ra, rb, -1, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
